time_base_gen: RTL

- Multi-channel programmable time-base generator.
- Successor to the fixed 1 s square-wave divider on the 50 MHz board clock.
- Each channel has a runtime-loadable divisor, produces a 1-cycle tick strobe plus a toggling square output, and runs in free-run or one-shot mode.
- Feeds display refresh, debouncers, blink and timeout logic in the lab designs.

---
 rtl/time_base_pkg.sv | 24 ++
 rtl/time_base_channel.sv | 76 +++++++
 rtl/time_base_gen.sv | 63 ++++++
 3 files changed

// File: rtl/time_base_pkg.sv
// Shared types and constants for the programmable time-base generator.
// Provides the channel mode enum, board-clock defaults and a divisor helper.
package time_base_pkg;

  typedef enum logic {
    TB_FREE    = 1'b0,
    TB_ONESHOT = 1'b1
  } tb_mode_e;

  // Tick divisor for a tick rate of f_hz on a clk_hz clock; 0 for f_hz = 0.
  function automatic int unsigned hz_to_div(input int unsigned clk_hz,
                                            input int unsigned f_hz);
    if (f_hz == 0) begin
      return 0;
    end
    return clk_hz / f_hz;
  endfunction

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
  // Half-period of a 1 Hz square wave: sq toggles once per tick.
  localparam int unsigned DIV_1HZ        = 25_000_000;
  localparam int unsigned TICK_1KHZ      = 50_000;

endpackage

// File: rtl/time_base_channel.sv
// One time-base channel: programmable period counter with tick strobe,
// toggling square output and free-run / one-shot modes.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   en            count enable (level)
//   clear         synchronous restart (cnt, tick, sq only)
//   we            decoded config write strobe for this channel
//   wdiv, wmode   divisor and mode loaded by a config write
//   tick          1-cycle strobe at each period end
//   sq            square output, toggles at each period end
//   active        channel armed / running
module time_base_channel
  import time_base_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             we,
  input  logic [CNT_W-1:0] wdiv,
  input  tb_mode_e         wmode,
  output logic             tick,
  output logic             sq,
  output logic             active
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  tb_mode_e         mode;
  logic             run_c;
  logic             period_end_c;

  // div = 0 parks the channel without touching active.
  always_comb begin
    run_c        = active && en && (div != '0);
    period_end_c = run_c && (cnt == (div - CNT_W'(1)));
  end

  // Priority: reset > clear > config write > counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      div    <= CNT_W'(DEFAULT_DIV);
      mode   <= TB_FREE;
      active <= 1'b1;
      tick   <= 1'b0;
      sq     <= 1'b1;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b1;
    end else if (we) begin
      div    <= wdiv;
      mode   <= wmode;
      cnt    <= '0;
      active <= 1'b1;
      tick   <= 1'b0;
    end else if (period_end_c) begin
      cnt  <= '0;
      tick <= 1'b1;
      sq   <= ~sq;
      if (mode == TB_ONESHOT) begin
        active <= 1'b0;
      end
    end else if (run_c) begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/time_base_gen.sv
// Multi-channel programmable time-base generator.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   ch_en         per-channel count enable
//   clear         synchronous restart of all channels
//   cfg_we        config write strobe (1 cycle)
//   cfg_ch        target channel; values >= N_CH are ignored
//   cfg_div       new divisor
//   cfg_mode      0 = free-run, 1 = one-shot
//   tick          per-channel 1-cycle period-end strobe
//   sq            per-channel square output
//   active        per-channel armed/running flag
module time_base_gen
  import time_base_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = DIV_1HZ,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             clear,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq,
  output logic [N_CH-1:0]  active
);

  // Catch nonsensical parameterisations at elaboration.
  if (N_CH < 1 || CLK_HZ == 0) begin : g_bad_param
    $error("time_base_gen: N_CH must be >= 1 and CLK_HZ nonzero");
  end

  logic [N_CH-1:0] ch_we_c;

  // Out-of-range cfg_ch matches no channel, so the write is dropped.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    assign ch_we_c[i] = cfg_we && (cfg_ch == CH_W'(i));

    time_base_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_channel (
      .clk    (clk),
      .reset  (reset),
      .en     (ch_en[i]),
      .clear  (clear),
      .we     (ch_we_c[i]),
      .wdiv   (cfg_div),
      .wmode  (tb_mode_e'(cfg_mode)),
      .tick   (tick[i]),
      .sq     (sq[i]),
      .active (active[i])
    );
  end

endmodule
